// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one SRAM-like memory bus between the instruction-fetch master and
// the data-memory master. One transaction is in flight at a time. Data has
// priority, and a starvation counter forces an instruction grant after
// STARVE_LIMIT consecutive data grants made while fetch was waiting.
//
// Ports
//   clk, resetn                      clock, async active-low reset
//   inst_req/wr/size/addr/wdata      instruction master request fields
//   inst_addr_ok/data_ok/rdata       instruction master handshakes + read data
//   data_req/wr/size/addr/wdata      data master request fields
//   data_addr_ok/data_ok/rdata       data master handshakes + read data
//   bus_req/wr/size/addr/wdata       bus request fields (from latched copy)
//   bus_addr_ok/data_ok/rdata        bus handshakes + read data
//   arb_busy                         high whenever a transaction is open
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,

    output logic        arb_busy
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned CNT_W  = 4;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // Request payload as latched at grant time.
    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } xfer_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    // owner encoding: 0 = instruction master, 1 = data master
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    xfer_t            xfer_q, xfer_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    xfer_t inst_xfer;
    xfer_t data_xfer;
    logic  grant_data;
    logic  starved;

    assign inst_xfer = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
    assign data_xfer = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};

    // Fetch has waited through LIMIT data grants: it takes the next slot.
    assign starved    = inst_req && (starve_cnt_q == LIMIT);
    assign grant_data = data_req && !starved;

    // State and latched-transaction registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            owner_q      <= OWN_INST;
            xfer_q       <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            xfer_q       <= xfer_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Next-state, grant and handshake routing.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        xfer_d       = xfer_q;
        starve_cnt_d = starve_cnt_q;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;

        case (state_q)
            IDLE: begin
                if (inst_req || data_req) begin
                    state_d = ADDR;
                    if (grant_data) begin
                        owner_d = OWN_DATA;
                        xfer_d  = data_xfer;
                        // Count only grants that made fetch wait.
                        if (inst_req) begin
                            if (starve_cnt_q < LIMIT) begin
                                starve_cnt_d = starve_cnt_q + CNT_W'(1);
                            end
                        end else begin
                            starve_cnt_d = '0;
                        end
                    end else begin
                        owner_d      = OWN_INST;
                        xfer_d       = inst_xfer;
                        starve_cnt_d = '0;
                    end
                end
            end

            ADDR: begin
                // bus_data_ok is not meaningful before the address phase ends.
                if (bus_addr_ok) begin
                    state_d      = DATA;
                    inst_addr_ok = (owner_q == OWN_INST);
                    data_addr_ok = (owner_q == OWN_DATA);
                end
            end

            DATA: begin
                if (bus_data_ok) begin
                    state_d      = IDLE;
                    inst_data_ok = (owner_q == OWN_INST);
                    data_data_ok = (owner_q == OWN_DATA);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus side is driven straight from the latched copy.
    assign bus_req   = (state_q == ADDR);
    assign bus_wr    = xfer_q.wr;
    assign bus_size  = xfer_q.size;
    assign bus_addr  = xfer_q.addr;
    assign bus_wdata = xfer_q.wdata;

    // Read data is shared; each master qualifies it with its own data_ok.
    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;

    assign arb_busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        arb_busy;

    int n_tests = 0;
    int n_fail  = 0;

    mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata),
        .arb_busy     (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_oks(input string tag, input bit ia, input bit id, input bit da, input bit dd);
        chk({tag, ".inst_addr_ok"}, 32'(inst_addr_ok), 32'(ia));
        chk({tag, ".inst_data_ok"}, 32'(inst_data_ok), 32'(id));
        chk({tag, ".data_addr_ok"}, 32'(data_addr_ok), 32'(da));
        chk({tag, ".data_data_ok"}, 32'(data_data_ok), 32'(dd));
    endtask

    // Advance to the next falling edge; inputs change and outputs are sampled there.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Zero-wait transaction starting from IDLE with requests already driven.
    task automatic xact(input string tag, input bit own_data, input logic [31:0] exp_addr,
                        input bit drop, input logic [3:0] exp_cnt, input logic [31:0] rdata);
        #1 chk({tag, ".idle"}, 32'(arb_busy), 32'd0);
        tick();
        bus_addr_ok = 1'b1;
        #1;
        chk({tag, ".bus_req"}, 32'(bus_req), 32'd1);
        chk({tag, ".bus_addr"}, bus_addr, exp_addr);
        chk({tag, ".starve_cnt"}, 32'(dut.starve_cnt_q), 32'(exp_cnt));
        chk_oks({tag, ".a"}, !own_data, 1'b0, own_data, 1'b0);
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = rdata;
        if (drop) begin
            if (own_data) data_req = 1'b0;
            else          inst_req = 1'b0;
        end
        #1;
        chk({tag, ".bus_req_d"}, 32'(bus_req), 32'd0);
        chk_oks({tag, ".d"}, 1'b0, !own_data, 1'b0, own_data);
        chk({tag, ".rdata"}, own_data ? data_rdata : inst_rdata, rdata);
        tick();
        bus_data_ok = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst.bus_req", 32'(bus_req), 32'd0);
        chk("rst.bus_wr", 32'(bus_wr), 32'd0);
        chk("rst.bus_size", 32'(bus_size), 32'd0);
        chk("rst.bus_addr", bus_addr, 32'd0);
        chk("rst.bus_wdata", bus_wdata, 32'd0);
        chk("rst.arb_busy", 32'(arb_busy), 32'd0);
        chk_oks("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        tick();

        // Lone instruction fetch, zero-wait bus
        inst_addr = 32'hBFC0_0000; inst_size = 2'd2; inst_req = 1'b1;
        xact("fetch", 1'b0, 32'hBFC0_0000, 1'b1, 4'd0, 32'h2408_0001);
        #1 chk("fetch.back_idle", 32'(arb_busy), 32'd0);

        // Data write with stalling slave
        data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h8000_1000;
        data_wdata = 32'hDEAD_BEEF; data_req = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus_addr_ok = (i == 3);
            #1;
            chk("wr.a.bus_req", 32'(bus_req), 32'd1);
            chk("wr.a.bus_wr", 32'(bus_wr), 32'd1);
            chk("wr.a.bus_size", 32'(bus_size), 32'd2);
            chk("wr.a.bus_addr", bus_addr, 32'h8000_1000);
            chk("wr.a.bus_wdata", bus_wdata, 32'hDEAD_BEEF);
            chk_oks("wr.a", 1'b0, 1'b0, (i == 3), 1'b0);
            tick();
        end
        bus_addr_ok = 1'b0;
        data_req = 1'b0; data_addr = 32'h1111_2222; data_wdata = 32'h3333_4444;
        for (int i = 0; i < 3; i++) begin
            bus_data_ok = (i == 2);
            #1;
            chk("wr.d.bus_req", 32'(bus_req), 32'd0);
            chk("wr.d.bus_addr", bus_addr, 32'h8000_1000);
            chk("wr.d.bus_wdata", bus_wdata, 32'hDEAD_BEEF);
            chk("wr.d.arb_busy", 32'(arb_busy), 32'd1);
            chk_oks("wr.d", 1'b0, 1'b0, 1'b0, (i == 2));
            tick();
        end
        bus_data_ok = 1'b0;
        data_wr = 1'b0;
        #1 chk("wr.back_idle", 32'(arb_busy), 32'd0);
        chk_oks("wr.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Simultaneous requests: data first, then inst
        inst_addr = 32'hBFC0_0040; data_addr = 32'h8000_2000;
        inst_req = 1'b1; data_req = 1'b1;
        xact("sim.d", 1'b1, 32'h8000_2000, 1'b1, 4'd1, 32'h0000_00D1);
        xact("sim.i", 1'b0, 32'hBFC0_0040, 1'b1, 4'd0, 32'h0000_00A1);

        // Starvation: four data grants, one inst, then data again
        #1 chk("st.cnt0", 32'(dut.starve_cnt_q), 32'd0);
        inst_addr = 32'hBFC0_0100; data_addr = 32'h8000_3000;
        inst_req = 1'b1; data_req = 1'b1;
        for (int k = 1; k <= 4; k++)
            xact("st.d", 1'b1, 32'h8000_3000, 1'b0, 4'(k), 32'(k));
        xact("st.i", 1'b0, 32'hBFC0_0100, 1'b1, 4'd0, 32'h0000_0BBB);
        xact("st.d2", 1'b1, 32'h8000_3000, 1'b1, 4'd0, 32'h0000_0CCC);

        // Reset mid-transaction
        data_addr = 32'h8000_4000; data_req = 1'b1;
        #1 chk("mr.idle", 32'(arb_busy), 32'd0);
        tick();
        bus_addr_ok = 1'b1;
        #1 chk("mr.addr_ok", 32'(data_addr_ok), 32'd1);
        tick();
        data_req = 1'b0; bus_addr_ok = 1'b0;
        #1 chk("mr.in_data", 32'(arb_busy), 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("mr.busy_rst", 32'(arb_busy), 32'd0);
        chk("mr.bus_addr_rst", bus_addr, 32'd0);
        chk_oks("mr.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        #1 resetn = 1'b1;
        bus_data_ok = 1'b1;
        tick();
        #1;
        chk("mr.after_busy", 32'(arb_busy), 32'd0);
        chk("mr.after_req", 32'(bus_req), 32'd0);
        chk_oks("mr.stray", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Spurious bus_data_ok in IDLE and ADDR
        #1;
        chk("sp.idle_busy", 32'(arb_busy), 32'd0);
        chk_oks("sp.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        data_addr = 32'h8000_5000; data_req = 1'b1;
        tick();
        #1;
        chk("sp.addr_req", 32'(bus_req), 32'd1);
        chk_oks("sp.addr", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        #1 chk("sp.still_addr", 32'(bus_req), 32'd1);
        bus_addr_ok = 1'b1;
        #1 chk_oks("sp.addr_ok", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        data_req = 1'b0; bus_addr_ok = 1'b0;
        #1;
        chk("sp.data_busy", 32'(arb_busy), 32'd1);
        chk_oks("sp.data", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        #1;
        chk("sp.end_busy", 32'(arb_busy), 32'd0);
        chk_oks("sp.end", 1'b0, 1'b0, 1'b0, 1'b0);
        bus_data_ok = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
